// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared constants for the load/store data path: default data width and
// memory depth, and the funct3 (instruction[14:12]) size/sign encodings that
// the ALU, control decode and data memory all agree on.
// -----------------------------------------------------------------------------
package data_mem_pkg;

    // Default data/address width and log2 of the doubleword count (256 x 64 = 2 KiB).
    localparam int DMEM_N         = 64;
    localparam int DMEM_ADDR_SIZE = 8;

    // Access size in funct3[1:0], unsigned flag in funct3[2].
    typedef enum logic [2:0] {
        F3_B   = 3'b000,
        F3_H   = 3'b001,
        F3_W   = 3'b010,
        F3_D   = 3'b011,
        F3_BU  = 3'b100,
        F3_HU  = 3'b101,
        F3_WU  = 3'b110,
        F3_ILL = 3'b111
    } funct3_e;

    // Low address bits that must be zero for a naturally aligned access
    // (equivalently: access size in bytes minus one).
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            2'b00:   m = 3'b000;
            2'b01:   m = 3'b001;
            2'b10:   m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_mem_lane.sv
// -----------------------------------------------------------------------------
// dmem_lane_ctrl
// Byte-lane steering for one doubleword access. From funct3 and the low three
// address bits it produces the store byte-enable mask, the store data shifted
// into its lanes, the load data extracted and sign/zero extended, and the
// legality flags for a load and for a store.
//
// Alignment handling is selected by the macro DMEM_MISALIGN_TRAP_EN:
//   defined   - a misaligned access is illegal (legal flags drop)
//   undefined - offending low address bits are dropped (access aligned down)
//
// Ports
//   funct3_i        access size/sign
//   addr_lo_i       byte offset within the doubleword
//   wdata_i         store data, low bytes used
//   rword_i         addressed doubleword as currently stored
//   byte_en_o       one bit per byte lane written by a store
//   wdata_sh_o      store data moved to its byte lanes
//   load_data_o     extended load result, zero when the load is illegal
//   load_legal_o    load with this funct3/offset is legal
//   store_legal_o   store with this funct3/offset is legal
// -----------------------------------------------------------------------------
module dmem_lane_ctrl
    import data_mem_pkg::*;
#(
    parameter int N = DMEM_N
) (
    input  logic [2:0]   funct3_i,
    input  logic [2:0]   addr_lo_i,
    input  logic [N-1:0] wdata_i,
    input  logic [N-1:0] rword_i,
    output logic [7:0]   byte_en_o,
    output logic [N-1:0] wdata_sh_o,
    output logic [N-1:0] load_data_o,
    output logic         load_legal_o,
    output logic         store_legal_o
);

    logic [2:0]   smask;
    logic [2:0]   off;
    logic         misaligned;
    logic [7:0]   size_be;
    logic [N-1:0] shifted;

    always_comb begin
        smask = size_mask(funct3_i[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = |(addr_lo_i & smask);
        off        = addr_lo_i;
`else
        misaligned = 1'b0;
        off        = addr_lo_i & ~smask;
`endif
        load_legal_o  = (funct3_i != F3_ILL) && !misaligned;
        store_legal_o = !funct3_i[2] && !misaligned;

        case (funct3_i[1:0])
            2'b00:   size_be = 8'h01;
            2'b01:   size_be = 8'h03;
            2'b10:   size_be = 8'h0F;
            default: size_be = 8'hFF;
        endcase
        byte_en_o  = size_be << off;
        wdata_sh_o = wdata_i << {off, 3'b000};

        // Bring the addressed byte down to lane 0, then extend.
        shifted = rword_i >> {off, 3'b000};
        case (funct3_e'(funct3_i))
            F3_B:    load_data_o = {{(N-8){shifted[7]}},   shifted[7:0]};
            F3_H:    load_data_o = {{(N-16){shifted[15]}}, shifted[15:0]};
            F3_W:    load_data_o = {{(N-32){shifted[31]}}, shifted[31:0]};
            F3_D:    load_data_o = shifted;
            F3_BU:   load_data_o = {{(N-8){1'b0}},  shifted[7:0]};
            F3_HU:   load_data_o = {{(N-16){1'b0}}, shifted[15:0]};
            F3_WU:   load_data_o = {{(N-32){1'b0}}, shifted[31:0]};
            default: load_data_o = '0;
        endcase
        if (!load_legal_o) begin
            load_data_o = '0;
        end
    end

endmodule

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Byte-addressed, little-endian data memory of 2**ADDR_SIZE doublewords with a
// combinational load path, edge-committed stores and a sticky fault capture
// for illegal accesses. Address bits above the memory size are ignored, so
// addresses wrap modulo the memory size.
//
// Alignment handling is selected by the macro DMEM_MISALIGN_TRAP_EN (see
// dmem_lane_ctrl): defined -> misaligned accesses fault; undefined -> they are
// aligned down and only an illegal funct3 faults.
//
// Request semantics: mem_read / mem_write are single-cycle requests with no
// back-pressure. A load is answered in the same cycle; a store takes effect at
// the next rising clk edge. Both may be high together: the load sees the
// contents from before that edge.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   mem_read      load request this cycle
//   mem_write     store request this cycle
//   funct3        access size and sign
//   addr          byte address
//   write_data    store data, low bytes used
//   fault_clr     clears the captured fault
//   read_data     load result (0 when no load or the load is illegal)
//   fault_valid   sticky fault flag
//   fault_addr    address of the first captured fault
// -----------------------------------------------------------------------------
module data_mem
    import data_mem_pkg::*;
#(
    parameter int N         = DMEM_N,
    parameter int ADDR_SIZE = DMEM_ADDR_SIZE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] write_data,
    input  logic         fault_clr,
    output logic [N-1:0] read_data,
    output logic         fault_valid,
    output logic [N-1:0] fault_addr
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [N-1:0]         mem_q [0:DEPTH-1];
    logic [ADDR_SIZE-1:0] word_idx;
    logic [N-1:0]         rword;
    logic [7:0]           byte_en;
    logic [N-1:0]         wdata_sh;
    logic [N-1:0]         load_data;
    logic                 load_legal;
    logic                 store_legal;
    logic                 access_fault;

    logic                 fault_valid_d, fault_valid_q;
    logic [N-1:0]         fault_addr_d,  fault_addr_q;

    assign word_idx = addr[ADDR_SIZE+2:3];
    assign rword    = mem_q[word_idx];

    dmem_lane_ctrl #(.N(N)) u_lane (
        .funct3_i      (funct3),
        .addr_lo_i     (addr[2:0]),
        .wdata_i       (write_data),
        .rword_i       (rword),
        .byte_en_o     (byte_en),
        .wdata_sh_o    (wdata_sh),
        .load_data_o   (load_data),
        .load_legal_o  (load_legal),
        .store_legal_o (store_legal)
    );

    assign read_data = mem_read ? load_data : '0;

    // Storage. The asynchronous clear also drops a store whose edge has not
    // yet arrived when rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_write && store_legal) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    assign access_fault = (mem_read && !load_legal) || (mem_write && !store_legal);

    // Only the first fault is kept; a clear in the same cycle as a new fault
    // lets the new one in.
    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_addr_d  = fault_addr_q;
        if (fault_clr) begin
            fault_valid_d = 1'b0;
        end
        if (access_fault && (!fault_valid_q || fault_clr)) begin
            fault_valid_d = 1'b1;
            fault_addr_d  = addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end else begin
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign fault_valid = fault_valid_q;
    assign fault_addr  = fault_addr_q;

endmodule
